// File: rtl/arbitro_pkg.sv
// Shared types and constants for the 12-way round-robin mux arbiter.
// Optional grant timeout is enabled with ARBITRO_TIMEOUT_EN.
package arbitro_pkg;

  localparam int N_REQ          = 12;
  localparam int W_SEL          = 4;
  localparam int TIMEOUT_CICLOS = 16;
  localparam int CNT_W          = 5;

  typedef enum logic [1:0] {
    OCIOSO,
    CONCEDIDO,
    ESPERA
  } estado_t;

  function automatic logic [N_REQ-1:0] um_quente(
    input logic [W_SEL-1:0] i
  );
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/arbitro_mux12_if.sv
// Request/grant/handshake bundle between the sources, the arbiter
// and the downstream consumer.
interface arbitro_mux12_if;
  import arbitro_pkg::*;

  logic [N_REQ-1:0] req;
  logic             pronto;
  logic [W_SEL-1:0] selecao;
  logic             valido;
  logic [N_REQ-1:0] ack;
  logic             erro_timeout;

  modport master (
    input  req,
    input  pronto,
    output selecao,
    output valido,
    output ack,
    output erro_timeout
  );

  modport slave (
    output req,
    output pronto,
    input  selecao,
    input  valido,
    input  ack,
    input  erro_timeout
  );

endinterface

// File: rtl/prio_rr12.sv
// Rotating priority encoder: first set request after ultimo,
// wrapping 11 -> 0; idx is always 0..11.
module prio_rr12
  import arbitro_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [W_SEL-1:0] ultimo,
  output logic [W_SEL-1:0] idx,
  output logic             achou
);

  logic [4:0] j;

  always_comb begin
    idx   = '0;
    achou = 1'b0;
    j     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = 5'(ultimo) + 5'(k);
      // two folds keep even an illegal ultimo inside 0..11
      if (j >= 5'd12) j = j - 5'd12;
      if (j >= 5'd12) j = j - 5'd12;
      if (!achou && req[j[3:0]]) begin
        idx   = j[3:0];
        achou = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_mux12.sv
// Round-robin arbiter driving the shared 12:1 mux select with a
// valid/ready handshake; ARBITRO_TIMEOUT_EN adds grant abandonment.
module arbitro_mux12
  import arbitro_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  arbitro_mux12_if.master  bus
);

  estado_t          state_q, state_d;
  logic [W_SEL-1:0] sel_q, sel_d;
  logic [W_SEL-1:0] ultimo_q, ultimo_d;
  logic             val_q, val_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [W_SEL-1:0] idx;
  logic             achou;

  prio_rr12 u_prio (
    .req    (bus.req),
    .ultimo (ultimo_q),
    .idx    (idx),
    .achou  (achou)
  );

`ifdef ARBITRO_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             erro_q, erro_d;
  logic             estouro;

  assign estouro = (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ultimo_d = ultimo_q;
    val_d    = val_q;
    ack_d    = '0;
`ifdef ARBITRO_TIMEOUT_EN
    cnt_d    = cnt_q;
    erro_d   = 1'b0;
`endif
    unique case (state_q)
      OCIOSO: begin
        if (achou) begin
          sel_d   = idx;
          val_d   = 1'b1;
          state_d = CONCEDIDO;
`ifdef ARBITRO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      CONCEDIDO: begin
        if (bus.pronto) begin
          ack_d    = um_quente(sel_q);
          ultimo_d = sel_q;
          val_d    = 1'b0;
          state_d  = ESPERA;
        end
`ifdef ARBITRO_TIMEOUT_EN
        else if (estouro) begin
          // pointer still advances so a stuck source cannot starve others
          ultimo_d = sel_q;
          val_d    = 1'b0;
          erro_d   = 1'b1;
          state_d  = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ESPERA:  state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= OCIOSO;
      sel_q    <= '0;
      ultimo_q <= W_SEL'(N_REQ - 1);
      val_q    <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ultimo_q <= ultimo_d;
      val_q    <= val_d;
      ack_q    <= ack_d;
    end
  end

`ifdef ARBITRO_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      erro_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      erro_q <= erro_d;
    end
  end

  assign bus.erro_timeout = erro_q;
`else
  assign bus.erro_timeout = 1'b0;
`endif

  assign bus.selecao = sel_q;
  assign bus.valido  = val_q;
  assign bus.ack     = ack_q;

endmodule

// File: tb/tb_arbitro_mux12.sv
// Self-checking bench for arbitro_mux12 with a queue of expected grants.
// Timeout scenario follows ARBITRO_TIMEOUT_EN like the design.
module tb_arbitro_mux12;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  int   exp_q[$];

  arbitro_mux12_if bus();

  arbitro_mux12 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.req    = '0;
    bus.pronto = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= lim; i++) begin
      if (bus.valido === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (i < lim) tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.selecao !== 4'd0)
      $display("FAIL rst_sel: got %0d want 0", bus.selecao);
    else pass_cnt++;
    total_cnt++;
    if (bus.valido !== 1'b0)
      $display("FAIL rst_valido: got %0b want 0", bus.valido);
    else pass_cnt++;
    total_cnt++;
    if (bus.ack !== 12'h000)
      $display("FAIL rst_ack: got %03h want 000", bus.ack);
    else pass_cnt++;
    total_cnt++;
    if (bus.erro_timeout !== 1'b0)
      $display("FAIL rst_erro: got %0b want 0", bus.erro_timeout);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int e;
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(0);
    bus.req    = 12'h001;
    bus.pronto = 1'b1;
    tick();
    total_cnt++;
    if (bus.valido !== 1'b1)
      $display("FAIL lat_valido: got %0b want 1", bus.valido);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.selecao !== 4'(e))
      $display("FAIL lat_sel: got %0d want %0d", bus.selecao, e);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h001 || bus.valido !== 1'b0)
      $display("FAIL acc_ack: got ack=%03h v=%0b want ack=001 v=0",
               bus.ack, bus.valido);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h000 || bus.valido !== 1'b0)
      $display("FAIL gap: got ack=%03h v=%0b want ack=000 v=0",
               bus.ack, bus.valido);
    else pass_cnt++;
    tick();
    e = exp_q.pop_front();
    total_cnt++;
    if (bus.valido !== 1'b1 || bus.selecao !== 4'(e))
      $display("FAIL regrant: got v=%0b sel=%0d want v=1 sel=%0d",
               bus.valido, bus.selecao, e);
    else pass_cnt++;
    bus.req = '0;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h001)
      $display("FAIL regrant_ack: got %03h want 001", bus.ack);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (bus.valido !== 1'b0 || bus.ack !== 12'h000)
      $display("FAIL idle: got v=%0b ack=%03h want v=0 ack=000",
               bus.valido, bus.ack);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [11:0] pat [2];
    int          seq [2][$];
    logic [11:0] one;
    bit          ok;
    int          e;
    pat[0] = 12'hFFF;
    pat[1] = 12'h811;
    for (int g = 0; g < 12; g++) seq[0].push_back(g);
    seq[0].push_back(0);
    seq[1] = '{0, 4, 11, 0};
    for (int s = 0; s < 2; s++) begin
      do_reset();
      foreach (seq[s][n]) exp_q.push_back(seq[s][n]);
      bus.req    = pat[s];
      bus.pronto = 1'b1;
      while (exp_q.size() > 0) begin
        wait_valid(6, ok);
        total_cnt++;
        if (!ok) begin
          $display("FAIL rr_wait: got no valido want valido in 6 cycles");
          break;
        end else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.selecao !== 4'(e))
          $display("FAIL rr_sel: got %0d want %0d", bus.selecao, e);
        else pass_cnt++;
        tick();
        one = 12'h001 << e;
        total_cnt++;
        if (bus.ack !== one)
          $display("FAIL rr_ack: got %03h want %03h", bus.ack, one);
        else pass_cnt++;
      end
      exp_q.delete();
      bus.req    = '0;
      bus.pronto = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_hold();
    bit ok;
    bit held;
    int e;
    do_reset();
    exp_q.push_back(5);
    exp_q.push_back(1);
    bus.req = 12'h020;
    wait_valid(4, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || bus.selecao !== 4'(e))
      $display("FAIL hold_grant: got v=%0b sel=%0d want v=1 sel=%0d",
               bus.valido, bus.selecao, e);
    else pass_cnt++;
    bus.req = 12'h002;
    held    = 1'b1;
    repeat (10) begin
      tick();
      if (bus.valido !== 1'b1 || bus.selecao !== 4'd5 ||
          bus.ack !== 12'h000)
        held = 1'b0;
    end
    total_cnt++;
    if (!held)
      $display("FAIL hold_stable: got sel=%0d v=%0b want sel=5 v=1",
               bus.selecao, bus.valido);
    else pass_cnt++;
    bus.pronto = 1'b1;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h020)
      $display("FAIL hold_ack: got %03h want 020", bus.ack);
    else pass_cnt++;
    wait_valid(4, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || bus.selecao !== 4'(e))
      $display("FAIL hold_next: got v=%0b sel=%0d want v=1 sel=%0d",
               bus.valido, bus.selecao, e);
    else pass_cnt++;
    bus.req = '0;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h002)
      $display("FAIL hold_next_ack: got %03h want 002", bus.ack);
    else pass_cnt++;
    bus.pronto = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    bit held;
    do_reset();
    bus.req    = 12'h008;
    bus.pronto = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || bus.selecao !== 4'd3)
      $display("FAIL to_grant: got v=%0b sel=%0d want v=1 sel=3",
               bus.valido, bus.selecao);
    else pass_cnt++;
`ifdef ARBITRO_TIMEOUT_EN
    exp_q.push_back(0);
    bus.req = 12'h009;
    held    = 1'b1;
    repeat (15) begin
      tick();
      if (bus.valido !== 1'b1 || bus.erro_timeout !== 1'b0)
        held = 1'b0;
    end
    total_cnt++;
    if (!held)
      $display("FAIL to_early: got v=%0b erro=%0b want v=1 erro=0",
               bus.valido, bus.erro_timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.erro_timeout !== 1'b1 || bus.valido !== 1'b0 ||
        bus.ack !== 12'h000)
      $display("FAIL to_pulse: got erro=%0b v=%0b ack=%03h want 1 0 000",
               bus.erro_timeout, bus.valido, bus.ack);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.erro_timeout !== 1'b0 || bus.ack !== 12'h000)
      $display("FAIL to_once: got erro=%0b ack=%03h want 0 000",
               bus.erro_timeout, bus.ack);
    else pass_cnt++;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || bus.selecao !== 4'(exp_q.pop_front()))
      $display("FAIL to_next: got v=%0b sel=%0d want v=1 sel=0",
               bus.valido, bus.selecao);
    else pass_cnt++;
    bus.pronto = 1'b1;
    bus.req    = '0;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h001)
      $display("FAIL to_next_ack: got %03h want 001", bus.ack);
    else pass_cnt++;
`else
    held = 1'b1;
    repeat (120) begin
      tick();
      if (bus.valido !== 1'b1 || bus.selecao !== 4'd3 ||
          bus.ack !== 12'h000 || bus.erro_timeout !== 1'b0)
        held = 1'b0;
    end
    total_cnt++;
    if (!held)
      $display("FAIL no_to_hold: got v=%0b sel=%0d erro=%0b want 1 3 0",
               bus.valido, bus.selecao, bus.erro_timeout);
    else pass_cnt++;
    bus.pronto = 1'b1;
    bus.req    = '0;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h008)
      $display("FAIL no_to_ack: got %03h want 008", bus.ack);
    else pass_cnt++;
`endif
    bus.pronto = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e;
    do_reset();
    bus.req    = 12'h040;
    bus.pronto = 1'b0;
    wait_valid(4, ok);
    total_cnt++;
    if (!ok || bus.selecao !== 4'd6)
      $display("FAIL mid_grant: got v=%0b sel=%0d want v=1 sel=6",
               bus.valido, bus.selecao);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.valido !== 1'b0 || bus.ack !== 12'h000 ||
        bus.selecao !== 4'd0)
      $display("FAIL mid_async: got v=%0b ack=%03h sel=%0d want 0 000 0",
               bus.valido, bus.ack, bus.selecao);
    else pass_cnt++;
    exp_q.push_back(5);
    bus.req = 12'h0A0;
    tick();
    reset = 1'b0;
    wait_valid(4, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || bus.selecao !== 4'(e))
      $display("FAIL mid_first: got v=%0b sel=%0d want v=1 sel=%0d",
               bus.valido, bus.selecao, e);
    else pass_cnt++;
    bus.pronto = 1'b1;
    bus.req    = '0;
    tick();
    total_cnt++;
    if (bus.ack !== 12'h020)
      $display("FAIL mid_ack: got %03h want 020", bus.ack);
    else pass_cnt++;
    bus.pronto = 1'b0;
    tick();
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    reset      = 1'b1;
    bus.req    = '0;
    bus.pronto = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
